// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory port, pipeline control inputs and IF/ID register outputs.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_stalled.
interface fetch_stage_if;
  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam int unsigned CLEN = 32;

  logic [XLEN-1:0] instr_adr;
  logic [ILEN-1:0] instr_data;
  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic            resume;
  logic [XLEN-1:0] ifid_pc;
  logic [XLEN-1:0] ifid_pc4;
  logic [ILEN-1:0] ifid_instr;
  logic            ifid_valid;
  logic            halted;
  logic            fault;
`ifdef FETCH_PERF_CNT_EN
  logic [CLEN-1:0] perf_fetched;
  logic [CLEN-1:0] perf_stalled;
`endif

  modport master (
`ifdef FETCH_PERF_CNT_EN
    output perf_fetched,
    output perf_stalled,
`endif
    output instr_adr,
    input  instr_data,
    input  stall,
    input  redirect,
    input  redirect_target,
    input  resume,
    output ifid_pc,
    output ifid_pc4,
    output ifid_instr,
    output ifid_valid,
    output halted,
    output fault
  );

  modport slave (
`ifdef FETCH_PERF_CNT_EN
    input  perf_fetched,
    input  perf_stalled,
`endif
    input  instr_adr,
    output instr_data,
    output stall,
    output redirect,
    output redirect_target,
    output resume,
    input  ifid_pc,
    input  ifid_pc4,
    input  ifid_instr,
    input  ifid_valid,
    input  halted,
    input  fault
  );
endinterface

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: owns the PC, drives InstructionMemory and fills the IF/ID register.
// Define FETCH_PERF_CNT_EN to add the fetched/stalled performance counters.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned MEM_SIZE = 16,
  parameter logic [31:0] HALT_ENC = 32'hD4400000
) (
  input logic          clk,
  input logic          reset,
  fetch_stage_if.master bus
);
  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam int unsigned WLEN = XLEN - 2;

  typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            pc_bad;
  logic            target_misaligned;
  logic            fetch_fire;

  assign pc_plus4          = pc + XLEN'(4);
  assign pc_bad            = (pc[XLEN-1:2] >= WLEN'(MEM_SIZE)) || (pc[1:0] != 2'b00);
  assign target_misaligned = bus.redirect_target[1:0] != 2'b00;
  assign fetch_fire        = (state == RUN) && !pc_bad && !bus.redirect && !bus.stall;

  assign bus.instr_adr = pc;
  assign bus.halted    = (state == HALT);
  assign bus.fault     = (state == FAULT);

  // Fetch FSM with PC and IF/ID register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= BOOT;
      pc             <= RESET_PC;
      bus.ifid_pc    <= '0;
      bus.ifid_pc4   <= '0;
      bus.ifid_instr <= '0;
      bus.ifid_valid <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          bus.ifid_valid <= 1'b0;
          state          <= RUN;
        end
        RUN: begin
          if (pc_bad) begin
            bus.ifid_valid <= 1'b0;
            state          <= FAULT;
          end else if (bus.redirect) begin
            bus.ifid_valid <= 1'b0;
            if (target_misaligned) state <= FAULT;
            else                   pc    <= bus.redirect_target;
          end else if (!bus.stall) begin
            bus.ifid_pc    <= pc;
            bus.ifid_pc4   <= pc_plus4;
            bus.ifid_instr <= bus.instr_data;
            bus.ifid_valid <= 1'b1;
            if (bus.instr_data == HALT_ENC) state <= HALT;
            else                            pc    <= pc_plus4;
          end
        end
        HALT: begin
          bus.ifid_valid <= 1'b0;
          if (bus.redirect) begin
            if (target_misaligned) begin
              state <= FAULT;
            end else begin
              pc    <= bus.redirect_target;
              state <= RUN;
            end
          end else if (bus.resume) begin
            pc    <= pc_plus4;
            state <= RUN;
          end
        end
        FAULT: begin
          bus.ifid_valid <= 1'b0;
        end
        default: begin
          bus.ifid_valid <= 1'b0;
          state          <= FAULT;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  localparam int unsigned CLEN = 32;
  logic stall_cycle;

  // A stalled cycle is a RUN cycle where stall is not overridden by redirect
  assign stall_cycle = (state == RUN) && bus.stall && !bus.redirect;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.perf_fetched <= '0;
      bus.perf_stalled <= '0;
    end else begin
      if (fetch_fire && (bus.perf_fetched != {CLEN{1'b1}}))
        bus.perf_fetched <= bus.perf_fetched + CLEN'(1);
      if (stall_cycle && (bus.perf_stalled != {CLEN{1'b1}}))
        bus.perf_stalled <= bus.perf_stalled + CLEN'(1);
    end
  end
`else
  logic unused_fire;
  assign unused_fire = fetch_fire;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected IF/ID captures are queued by the stimulus thread
// and popped by an independent monitor on every cycle the DUT shows ifid_valid.
module tb_fetch_stage;
  localparam logic [31:0] HALT_ENC = 32'hD4400000;
  localparam logic [31:0] W0 = 32'h8B020020;
  localparam logic [31:0] W1 = 32'hCB020020;
  localparam logic [31:0] W2 = 32'hF8400020;
  localparam logic [31:0] W3 = 32'h00000000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } cap_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_stage_if bus ();
  fetch_stage dut (.clk(clk), .reset(reset), .bus(bus));

  logic [31:0] mem [16];
  always_comb begin
    if (bus.instr_adr[63:6] == 58'd0) bus.instr_data = mem[bus.instr_adr[5:2]];
    else                              bus.instr_data = 32'h0;
  end

  cap_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic push(input logic [63:0] pc, input logic [31:0] instr);
    cap_t e;
    e.pc = pc;
    e.instr = instr;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: every live IF/ID cycle must match the next queued capture
  initial begin
    cap_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && bus.ifid_valid === 1'b1) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL ifid_unexpected: got valid capture pc %h, expected none", bus.ifid_pc);
        end else begin
          e = q.pop_front();
          if (bus.ifid_pc !== e.pc || bus.ifid_pc4 !== e.pc + 64'd4 || bus.ifid_instr !== e.instr) begin
            n_fail++;
            $display("FAIL ifid_capture: got pc %h pc4 %h instr %h, expected pc %h pc4 %h instr %h",
                     bus.ifid_pc, bus.ifid_pc4, bus.ifid_instr, e.pc, e.pc + 64'd4, e.instr);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = W0; mem[1] = W1; mem[2] = W2; mem[3] = W3;
    reset = 1'b1;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_target = 64'h0; bus.resume = 1'b0;
    tick(); tick();

    chk("rst_adr", bus.instr_adr, 64'h0);
    chk("rst_valid", 64'(bus.ifid_valid), 64'h0);
    chk("rst_ifid_pc", bus.ifid_pc, 64'h0);
    chk("rst_ifid_pc4", bus.ifid_pc4, 64'h0);
    chk("rst_ifid_instr", 64'(bus.ifid_instr), 64'h0);
    chk("rst_halted", 64'(bus.halted), 64'h0);
    chk("rst_fault", 64'(bus.fault), 64'h0);
    reset = 1'b0;

    tick();
    chk("boot_valid", 64'(bus.ifid_valid), 64'h0);
    chk("boot_adr", bus.instr_adr, 64'h0);

    push(64'd0, W0); tick();
    chk("seq_adr4", bus.instr_adr, 64'd4);
    push(64'd4, W1); tick();
    chk("seq_adr8", bus.instr_adr, 64'd8);

    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(64'd4, W1); tick();
      chk("stall_adr", bus.instr_adr, 64'd8);
      chk("stall_valid", 64'(bus.ifid_valid), 64'h1);
    end
    bus.stall = 1'b0;

    push(64'd8, W2); tick();
    chk("seq_adr12", bus.instr_adr, 64'd12);
    push(64'd12, W3); tick();
    chk("seq_adr16", bus.instr_adr, 64'd16);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", 64'(bus.perf_fetched), 64'd4);
    chk("perf_stalled", 64'(bus.perf_stalled), 64'd3);
`endif

    bus.redirect = 1'b1; bus.stall = 1'b1; bus.redirect_target = 64'd4;
    tick();
    chk("redir_adr", bus.instr_adr, 64'd4);
    chk("redir_flush", 64'(bus.ifid_valid), 64'h0);
    bus.redirect = 1'b0; bus.stall = 1'b0;
    push(64'd4, W1); tick();
    chk("redir_valid", 64'(bus.ifid_valid), 64'h1);
    chk("redir_next_adr", bus.instr_adr, 64'd8);

    mem[2] = HALT_ENC;
    push(64'd8, HALT_ENC); tick();
    chk("halt_halted", 64'(bus.halted), 64'h1);
    chk("halt_adr", bus.instr_adr, 64'd8);
    tick();
    chk("halt_valid0", 64'(bus.ifid_valid), 64'h0);
    chk("halt_hold_adr", bus.instr_adr, 64'd8);
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    chk("resume_halted", 64'(bus.halted), 64'h0);
    chk("resume_adr", bus.instr_adr, 64'd12);
    mem[2] = W2;
    push(64'd12, W3); tick();
    chk("resume_run_adr", bus.instr_adr, 64'd16);

    bus.redirect = 1'b1; bus.redirect_target = 64'h6;
    tick();
    chk("mis_fault", 64'(bus.fault), 64'h1);
    chk("mis_adr", bus.instr_adr, 64'd16);
    chk("mis_valid", 64'(bus.ifid_valid), 64'h0);
    bus.redirect_target = 64'h0; bus.resume = 1'b1; bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fault_sticky", 64'(bus.fault), 64'h1);
      chk("fault_adr", bus.instr_adr, 64'd16);
      chk("fault_valid", 64'(bus.ifid_valid), 64'h0);
    end
    bus.redirect = 1'b0; bus.resume = 1'b0; bus.stall = 1'b0;

    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("async_fault", 64'(bus.fault), 64'h0);
    chk("async_adr", bus.instr_adr, 64'h0);
    chk("async_ifid_pc", bus.ifid_pc, 64'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("async_perf", 64'(bus.perf_fetched), 64'h0);
`endif
    @(negedge clk);
    reset = 1'b0;

    tick();
    chk("boot2_valid", 64'(bus.ifid_valid), 64'h0);
    push(64'd0, W0); tick();
    chk("boot2_adr", bus.instr_adr, 64'd4);

    bus.redirect = 1'b1; bus.redirect_target = 64'd64;
    tick();
    bus.redirect = 1'b0;
    chk("oor_adr", bus.instr_adr, 64'd64);
    chk("oor_not_yet", 64'(bus.fault), 64'h0);
    tick();
    chk("oor_fault", 64'(bus.fault), 64'h1);
    chk("oor_valid", 64'(bus.ifid_valid), 64'h0);

    tick();
    chk("queue_drained", 64'(q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
